// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation encodings and the execute-stage FSM state.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } ex_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result, signed-overflow flag for ADD/SUB, and zero flag.
module alu
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  aluop_t            op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] result,
  output logic              overflow,
  output logic              zero
);

  localparam int unsigned ShW = $clog2(WORD_W);
  localparam int unsigned Msb = WORD_W - 1;

  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    unique case (op)
      AluAdd: begin
        result   = sum;
        overflow = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
      end
      AluSub: begin
        result   = diff;
        // Subtraction is a + ~b + 1, so the sign test is against ~b.
        overflow = (a[Msb] == ~b[Msb]) && (diff[Msb] != a[Msb]);
      end
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluXor:  result = a ^ b;
      AluNor:  result = ~(a | b);
      AluSlt:  result = {{(WORD_W-1){1'b0}}, $signed(a) < $signed(b)};
      AluSltu: result = {{(WORD_W-1){1'b0}}, a < b};
      AluSll:  result = b << a[ShW-1:0];
      AluSrl:  result = b >> a[ShW-1:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/pipeline_execute_stage.sv
// Execute stage: runs the ALU on ID/EX fields and registers the EX/MEM latch,
// handling stall/flush, overflow trapping and sticky halt.
module pipeline_execute_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W        = 32,
  parameter bit          OF_TRAP_HALTS = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  aluop_t            ID_alu_op_OUT,
  input  logic [WORD_W-1:0] ID_ALUSrc1_OUT,
  input  logic [WORD_W-1:0] ID_ALUSrc2_OUT,
  input  logic [WORD_W-1:0] ID_rdat2_OUT,
  input  logic [WORD_W-1:0] ID_RegDest_OUT,
  input  logic              ID_RegWen_OUT,
  input  logic              ID_mem2reg_OUT,
  input  logic              ID_pc2reg_OUT,
  input  logic              ID_MemWrite_OUT,
  input  logic              ID_careOF_OUT,
  input  logic              ID_halt_OUT,
  input  logic [WORD_W-1:0] ID_npc_OUT,
  input  logic              mem_stall,
  input  logic              ex_flush,
  output logic              ex_ready,
  output logic              EX_valid,
  output logic [WORD_W-1:0] EX_result,
  output logic [WORD_W-1:0] EX_rdat2,
  output logic [4:0]        EX_wsel,
  output logic              EX_RegWen,
  output logic              EX_mem2reg,
  output logic              EX_MemWrite,
  output logic              EX_halt,
  output logic              EX_overflow,
  output logic              EX_zero
);

  ex_state_t         state;
  logic [WORD_W-1:0] alu_result;
  logic              alu_overflow;
  logic              alu_zero;
  logic              bubble;
  logic              trap;
  logic              halt_next;
  logic              unused_regdest;

  assign unused_regdest = ^ID_RegDest_OUT[WORD_W-1:5];

  alu #(
    .WORD_W(WORD_W)
  ) u_alu (
    .op      (ID_alu_op_OUT),
    .a       (ID_ALUSrc1_OUT),
    .b       (ID_ALUSrc2_OUT),
    .result  (alu_result),
    .overflow(alu_overflow),
    .zero    (alu_zero)
  );

  assign ex_ready  = !mem_stall && (state != HALTED);
  assign bubble    = ex_flush || !id_valid;
  // A pc2reg instruction discards the ALU result, so it can never trap.
  assign trap      = ID_careOF_OUT && alu_overflow && !ID_pc2reg_OUT;
  assign halt_next = ID_halt_OUT || (trap && OF_TRAP_HALTS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      EX_valid    <= 1'b0;
      EX_result   <= '0;
      EX_rdat2    <= '0;
      EX_wsel     <= '0;
      EX_RegWen   <= 1'b0;
      EX_mem2reg  <= 1'b0;
      EX_MemWrite <= 1'b0;
      EX_halt     <= 1'b0;
      EX_overflow <= 1'b0;
      EX_zero     <= 1'b0;
    end else begin
      unique case (state)
        HALTED: state <= HALTED;
        default: begin
          if (ex_ready && !bubble && halt_next) state <= HALTED;
          else if (mem_stall)                   state <= HOLD;
          else                                  state <= RUN;
        end
      endcase

      // Latch only moves when accepting; HALTED keeps ex_ready low, so EX_halt sticks.
      if (ex_ready) begin
        if (bubble) begin
          EX_valid    <= 1'b0;
          EX_RegWen   <= 1'b0;
          EX_mem2reg  <= 1'b0;
          EX_MemWrite <= 1'b0;
          EX_halt     <= 1'b0;
          EX_overflow <= 1'b0;
        end else begin
          EX_valid    <= 1'b1;
          EX_result   <= ID_pc2reg_OUT ? ID_npc_OUT : alu_result;
          EX_rdat2    <= ID_rdat2_OUT;
          EX_wsel     <= ID_RegDest_OUT[4:0];
          EX_RegWen   <= ID_RegWen_OUT && !trap;
          EX_mem2reg  <= ID_mem2reg_OUT;
          EX_MemWrite <= ID_MemWrite_OUT && !trap;
          EX_halt     <= halt_next;
          EX_overflow <= trap;
          EX_zero     <= alu_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_execute_stage.sv
// Directed bench for pipeline_execute_stage with hand-computed expectations.
module tb_pipeline_execute_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        id_valid;
  aluop_t      ID_alu_op_OUT;
  logic [31:0] ID_ALUSrc1_OUT, ID_ALUSrc2_OUT, ID_rdat2_OUT, ID_RegDest_OUT, ID_npc_OUT;
  logic        ID_RegWen_OUT, ID_mem2reg_OUT, ID_pc2reg_OUT, ID_MemWrite_OUT;
  logic        ID_careOF_OUT, ID_halt_OUT;
  logic        mem_stall, ex_flush;
  logic        ex_ready, EX_valid;
  logic [31:0] EX_result, EX_rdat2;
  logic [4:0]  EX_wsel;
  logic        EX_RegWen, EX_mem2reg, EX_MemWrite, EX_halt, EX_overflow, EX_zero;

  // {valid, RegWen, mem2reg, MemWrite, halt, overflow, zero}
  logic [6:0]  ex_ctl;
  assign ex_ctl = {EX_valid, EX_RegWen, EX_mem2reg, EX_MemWrite, EX_halt, EX_overflow, EX_zero};

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  pipeline_execute_stage #(
    .WORD_W(32),
    .OF_TRAP_HALTS(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid),
    .ID_alu_op_OUT(ID_alu_op_OUT), .ID_ALUSrc1_OUT(ID_ALUSrc1_OUT),
    .ID_ALUSrc2_OUT(ID_ALUSrc2_OUT), .ID_rdat2_OUT(ID_rdat2_OUT),
    .ID_RegDest_OUT(ID_RegDest_OUT), .ID_RegWen_OUT(ID_RegWen_OUT),
    .ID_mem2reg_OUT(ID_mem2reg_OUT), .ID_pc2reg_OUT(ID_pc2reg_OUT),
    .ID_MemWrite_OUT(ID_MemWrite_OUT), .ID_careOF_OUT(ID_careOF_OUT),
    .ID_halt_OUT(ID_halt_OUT), .ID_npc_OUT(ID_npc_OUT),
    .mem_stall(mem_stall), .ex_flush(ex_flush), .ex_ready(ex_ready),
    .EX_valid(EX_valid), .EX_result(EX_result), .EX_rdat2(EX_rdat2), .EX_wsel(EX_wsel),
    .EX_RegWen(EX_RegWen), .EX_mem2reg(EX_mem2reg), .EX_MemWrite(EX_MemWrite),
    .EX_halt(EX_halt), .EX_overflow(EX_overflow), .EX_zero(EX_zero)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] rd, input logic regwen, input logic m2r,
                           input logic memw, input logic careof, input logic halt);
    id_valid        = 1'b1;
    ID_alu_op_OUT   = op;
    ID_ALUSrc1_OUT  = a;
    ID_ALUSrc2_OUT  = b;
    ID_RegDest_OUT  = rd;
    ID_RegWen_OUT   = regwen;
    ID_mem2reg_OUT  = m2r;
    ID_MemWrite_OUT = memw;
    ID_careOF_OUT   = careof;
    ID_halt_OUT     = halt;
    ID_pc2reg_OUT   = 1'b0;
    ID_npc_OUT      = 32'h0;
    ID_rdat2_OUT    = 32'h0;
  endtask

  task automatic test_reset();
    RST = 1'b1; mem_stall = 1'b0; ex_flush = 1'b0;
    set_instr(AluAdd, 32'd9, 32'd9, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    RST = 1'b0;
    vectors++;
    if (ex_ctl !== 7'b0 || EX_result !== 32'h0 || EX_rdat2 !== 32'h0 || EX_wsel !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: ctl=%b result=%h rdat2=%h wsel=%0d, required all zero",
               ex_ctl, EX_result, EX_rdat2, EX_wsel);
    end
    vectors++;
    if (ex_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b required 1", ex_ready);
    end
  endtask

  task automatic test_add();
    set_instr(AluAdd, 32'd5, 32'd7, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    vectors++;
    if (EX_result !== 32'd12 || EX_wsel !== 5'd3 || ex_ctl !== 7'b1100000) begin
      miscompares++;
      $display("FAIL add: result=%h wsel=%0d ctl=%b, required 0000000c 3 1100000",
               EX_result, EX_wsel, ex_ctl);
    end
  endtask

  task automatic test_sub_no_trap();
    set_instr(AluSub, 32'h80000000, 32'd1, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    vectors++;
    if (EX_result !== 32'h7fffffff || ex_ctl !== 7'b1100000) begin
      miscompares++;
      $display("FAIL sub_no_trap: result=%h ctl=%b, required 7fffffff 1100000", EX_result, ex_ctl);
    end
  endtask

  task automatic test_slt();
    set_instr(AluSlt, 32'hffffffff, 32'd1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    vectors++;
    if (EX_result !== 32'd1 || EX_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL slt: result=%h zero=%b, required 00000001 0", EX_result, EX_zero);
    end
    set_instr(AluSltu, 32'hffffffff, 32'd1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    vectors++;
    if (EX_result !== 32'd0 || EX_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL sltu: result=%h zero=%b, required 00000000 1", EX_result, EX_zero);
    end
    set_instr(AluSll, 32'd4, 32'h0000_00f1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    vectors++;
    if (EX_result !== 32'h0000_0f10) begin
      miscompares++;
      $display("FAIL sll: result=%h required 00000f10", EX_result);
    end
  endtask

  task automatic test_stall();
    set_instr(AluAdd, 32'd100, 32'd4, 32'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    vectors++;
    if (EX_result !== 32'd104 || EX_wsel !== 5'd8 || ex_ctl !== 7'b1110000) begin
      miscompares++;
      $display("FAIL load: result=%h wsel=%0d ctl=%b, required 00000068 8 1110000",
               EX_result, EX_wsel, ex_ctl);
    end
    mem_stall = 1'b1;
    set_instr(AluAdd, 32'd1, 32'd2, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (EX_result !== 32'd104 || EX_wsel !== 5'd8 || ex_ctl !== 7'b1110000 ||
          ex_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: result=%h wsel=%0d ctl=%b ready=%b, required 00000068 8 1110000 0",
                 i, EX_result, EX_wsel, ex_ctl, ex_ready);
      end
    end
    mem_stall = 1'b0;
    #1;
    vectors++;
    if (ex_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release_ready: got %b required 1", ex_ready);
    end
    step();
    vectors++;
    if (EX_result !== 32'd3 || EX_wsel !== 5'd9 || ex_ctl !== 7'b1100000) begin
      miscompares++;
      $display("FAIL stall_release_add: result=%h wsel=%0d ctl=%b, required 00000003 9 1100000",
               EX_result, EX_wsel, ex_ctl);
    end
  endtask

  task automatic test_flush();
    set_instr(AluAdd, 32'd16, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ID_rdat2_OUT = 32'hcafe_0001;
    ex_flush = 1'b1;
    step();
    ex_flush = 1'b0;
    vectors++;
    if (EX_valid !== 1'b0 || EX_MemWrite !== 1'b0 || EX_RegWen !== 1'b0 || EX_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_store: valid=%b memwrite=%b regwen=%b halt=%b, required 0 0 0 0",
               EX_valid, EX_MemWrite, EX_RegWen, EX_halt);
    end
    set_instr(AluAdd, 32'd1, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    step();
    vectors++;
    if (EX_valid !== 1'b0 || EX_RegWen !== 1'b0) begin
      miscompares++;
      $display("FAIL invalid_bubble: valid=%b regwen=%b, required 0 0", EX_valid, EX_RegWen);
    end
  endtask

  task automatic test_flush_stall();
    set_instr(AluOr, 32'h0f0f0000, 32'h000000f0, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_instr(AluAdd, 32'd32, 32'd8, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ID_rdat2_OUT = 32'hdead_beef;
    mem_stall = 1'b1;
    ex_flush = 1'b1;
    step();
    vectors++;
    if (EX_result !== 32'h0f0f00f0 || EX_wsel !== 5'd6 || ex_ctl !== 7'b1100000) begin
      miscompares++;
      $display("FAIL flush_stall_hold: result=%h wsel=%0d ctl=%b, required 0f0f00f0 6 1100000",
               EX_result, EX_wsel, ex_ctl);
    end
    mem_stall = 1'b0;
    ex_flush = 1'b0;
    step();
    vectors++;
    if (EX_result !== 32'd40 || EX_rdat2 !== 32'hdead_beef || ex_ctl !== 7'b1001000) begin
      miscompares++;
      $display("FAIL store_after_stall: result=%h rdat2=%h ctl=%b, required 00000028 deadbeef 1001000",
               EX_result, EX_rdat2, ex_ctl);
    end
  endtask

  task automatic test_jal_halt();
    set_instr(AluAdd, 32'd0, 32'd0, 32'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ID_pc2reg_OUT = 1'b1;
    ID_npc_OUT = 32'h0000_0044;
    step();
    vectors++;
    if (EX_result !== 32'h44 || EX_wsel !== 5'd31 || ex_ctl !== 7'b1100001) begin
      miscompares++;
      $display("FAIL jal: result=%h wsel=%0d ctl=%b, required 00000044 31 1100001",
               EX_result, EX_wsel, ex_ctl);
    end
    set_instr(AluAdd, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    vectors++;
    if (EX_halt !== 1'b1 || EX_result !== 32'd4 || ex_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL halt: halt=%b result=%h ready=%b, required 1 00000004 0",
               EX_halt, EX_result, ex_ready);
    end
    set_instr(AluAdd, 32'd10, 32'd10, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (EX_halt !== 1'b1 || EX_result !== 32'd4 || ex_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_sticky[%0d]: halt=%b result=%h ready=%b, required 1 00000004 0",
                 i, EX_halt, EX_result, ex_ready);
      end
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    vectors++;
    if (ex_ctl !== 7'b0 || EX_result !== 32'h0 || EX_wsel !== 5'd0 || ex_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_from_halt: ctl=%b result=%h wsel=%0d ready=%b, required 0 0 0 1",
               ex_ctl, EX_result, EX_wsel, ex_ready);
    end
  endtask

  task automatic test_overflow_trap();
    set_instr(AluSub, 32'h80000000, 32'd1, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    vectors++;
    if (EX_overflow !== 1'b1 || EX_RegWen !== 1'b0 || EX_halt !== 1'b1 || ex_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_trap: of=%b regwen=%b halt=%b ready=%b, required 1 0 1 0",
               EX_overflow, EX_RegWen, EX_halt, ex_ready);
    end
    set_instr(AluAdd, 32'd5, 32'd7, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    vectors++;
    if (EX_result !== 32'h7fffffff || EX_wsel !== 5'd4 || EX_halt !== 1'b1 ||
        EX_RegWen !== 1'b0) begin
      miscompares++;
      $display("FAIL after_trap_ignored: result=%h wsel=%0d halt=%b regwen=%b, required 7fffffff 4 1 0",
               EX_result, EX_wsel, EX_halt, EX_RegWen);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    vectors++;
    if (ex_ctl !== 7'b0 || ex_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_after_trap: ctl=%b ready=%b, required 0000000 1", ex_ctl, ex_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_no_trap();
    test_slt();
    test_stall();
    test_flush();
    test_flush_stall();
    test_jal_halt();
    test_overflow_trap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
